fifo_stream_reader: RTL and testbench

Read-side controller for a single-clock `pmi_fifo` instance. It issues `RdEn` to the FIFO and compensates for the FIFO read latency (1 cycle for `pmi_regmode` "noreg", 2 cycles for "reg"). Returned words are captured into a small skid buffer and presented downstream as a valid/ready stream. Sits between any `pmi_fifo` read port and a back-pressuring consumer, and sustains one word per clock when the consumer is always ready.

---
 rtl/fifo_stream_reader.sv | 101 ++++++++++
 tb/tb_fifo_stream_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side controller for a single-clock FIFO with 1- or 2-cycle read latency.
// Returned words land in a small skid buffer and leave as a valid/ready stream.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        FifoEmpty,
  input  logic [DATA_WIDTH-1:0]       FifoQ,
  output logic                        FifoRdEn,
  output logic [DATA_WIDTH-1:0]       OutData,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic [$clog2(BUF_DEPTH):0]  Occupancy,
  output logic [15:0]                 ReadCount
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(BUF_DEPTH);

  logic [RD_LATENCY-1:0]  inflight;
  logic [CNT_W-1:0]       count;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [15:0]            read_count;
  logic [DATA_WIDTH-1:0]  buf_mem [BUF_DEPTH];

  logic                   capture;
  logic                   pop;
  logic                   rd_en;
  logic [CNT_W:0]         inflight_cnt;
  logic [CNT_W:0]         credits;

  // Stream handshake: a word transfers on every cycle where OutValid and
  // OutReady are both high; while OutValid is high and OutReady low, OutData
  // and OutValid hold steady.
  assign capture = inflight[RD_LATENCY-1];
  assign pop     = OutValid & OutReady;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + {{CNT_W{1'b0}}, inflight[i]};
    end
  end

  // Words already committed (buffered or in flight) must never exceed the
  // buffer; counting this cycle's pop lets the read path run at full rate.
  assign credits = inflight_cnt + {1'b0, count} - {{CNT_W{1'b0}}, pop};
  assign rd_en   = !Reset && !FifoEmpty && (credits < DEPTH_W);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      inflight <= '0;
    end else begin
      inflight[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        inflight[i] <= inflight[i-1];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      read_count <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        read_count <= read_count + 16'd1;
      end
      case ({capture, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; contents are only observed once count says so.
  always_ff @(posedge Clock) begin
    if (capture) begin
      buf_mem[wr_ptr] <= FifoQ;
    end
  end

  assign FifoRdEn  = rd_en;
  assign OutValid  = (count != '0);
  assign OutData   = buf_mem[rd_ptr];
  assign Occupancy = count;
  assign ReadCount = read_count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: one instance per read latency sharing a FIFO
// model; the idle instance is held in reset while the other is exercised.
module tb_fifo_stream_reader;

  logic        clk;
  logic        rst1, rst2;
  logic        out_ready;
  logic        flush;
  int          lat_sel;

  logic        rden1, rden2, ov1, ov2;
  logic [7:0]  od1, od2;
  logic [2:0]  occ1, occ2;
  logic [15:0] rc1, rc2;

  logic [7:0]  fifo_mem [0:69999];
  int          wr_idx;
  int          rd_idx;
  logic [7:0]  q1, q2;
  logic        fifo_empty;
  logic        fifo_rd_en;

  logic        act_valid, act_rden;
  logic [7:0]  act_data;
  logic [2:0]  act_occ;
  logic [15:0] act_rc;

  logic [7:0]  exp_q[$];
  int          checks;
  int          errors;
  int          pop_cnt;
  int          rden_cnt;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(4)) u_dut1 (
    .Clock(clk), .Reset(rst1), .FifoEmpty(fifo_empty), .FifoQ(q1),
    .FifoRdEn(rden1), .OutData(od1), .OutValid(ov1), .OutReady(out_ready),
    .Occupancy(occ1), .ReadCount(rc1)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .RD_LATENCY(2), .BUF_DEPTH(4)) u_dut2 (
    .Clock(clk), .Reset(rst2), .FifoEmpty(fifo_empty), .FifoQ(q2),
    .FifoRdEn(rden2), .OutData(od2), .OutValid(ov2), .OutReady(out_ready),
    .Occupancy(occ2), .ReadCount(rc2)
  );

  assign act_valid = (lat_sel == 1) ? ov1   : ov2;
  assign act_rden  = (lat_sel == 1) ? rden1 : rden2;
  assign act_data  = (lat_sel == 1) ? od1   : od2;
  assign act_occ   = (lat_sel == 1) ? occ1  : occ2;
  assign act_rc    = (lat_sel == 1) ? rc1   : rc2;

  // FIFO model: q1 is the "noreg" output, q2 the extra "reg" output stage
  assign fifo_empty = (rd_idx == wr_idx);
  assign fifo_rd_en = rden1 | rden2;

  initial rd_idx = 0;
  always @(posedge clk) begin
    if (flush) begin
      rd_idx <= wr_idx;
    end else if (fifo_rd_en && !fifo_empty) begin
      q1     <= fifo_mem[rd_idx];
      rd_idx <= rd_idx + 1;
    end
    q2 <= q1;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (act_rden) rden_cnt++;
    if (act_valid && out_ready) begin
      pop_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %02h, expected no word", act_data);
      end else begin
        logic [7:0] exp_w;
        exp_w = exp_q.pop_front();
        if (act_data !== exp_w) begin
          errors++;
          $display("FAIL out_data: got %02h, expected %02h", act_data, exp_w);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w, input bit expect_out);
    fifo_mem[wr_idx] = w;
    wr_idx = wr_idx + 1;
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic select_dut(input int lat);
    rst1 = 1'b1;
    rst2 = 1'b1;
    lat_sel = lat;
    tick();
    tick();
    if (lat == 1) rst1 = 1'b0;
    else          rst2 = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!act_valid && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!act_valid) begin
      errors++;
      $display("FAIL %s: OutValid=0 after %0d cycles, expected 1", name, budget);
    end
  endtask

  task automatic run_stream(input int lat);
    int snap;
    select_dut(lat);
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) push_word(8'(i), 1'b1);
    wait_valid("stream_start", 10);
    snap = pop_cnt;
    for (int i = 0; i < 16; i++) tick();
    check("stream_pops_contiguous", pop_cnt - snap, 16);
    check("stream_valid_after", act_valid, 0);
    check("stream_read_count", act_rc, 16);
  endtask

  initial begin
    int snap;
    int n;
    checks   = 0;
    errors   = 0;
    pop_cnt  = 0;
    rden_cnt = 0;
    wr_idx   = 0;
    flush    = 1'b0;
    out_ready = 1'b1;
    lat_sel  = 2;
    rst1     = 1'b1;
    rst2     = 1'b1;

    // reset values with a non-empty FIFO
    push_word(8'h3C, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_rden", act_rden, 0);
      check("rst_valid", act_valid, 0);
      check("rst_occupancy", act_occ, 0);
      check("rst_read_count", act_rc, 0);
    end
    rst2 = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    check("rst_word_drained", act_rc, 1);

    // single word: read in cycle 0, visible in cycle 3 only
    select_dut(2);
    out_ready = 1'b1;
    tick();
    push_word(8'hA5, 1'b1);
    #1;
    check("single_rden_c0", act_rden, 1);
    tick();
    check("single_rden_c1", act_rden, 0);
    check("single_valid_c1", act_valid, 0);
    tick();
    check("single_valid_c2", act_valid, 0);
    tick();
    check("single_valid_c3", act_valid, 1);
    check("single_data_c3", act_data, 8'hA5);
    tick();
    check("single_valid_c4", act_valid, 0);
    check("single_read_count", act_rc, 1);

    // streaming at both latencies
    run_stream(1);
    run_stream(2);

    // back-pressure
    select_dut(2);
    out_ready = 1'b0;
    tick();
    snap = rden_cnt;
    for (int i = 0; i < 10; i++) push_word(8'h40 + 8'(i), 1'b1);
    for (int c = 0; c < 20; c++) tick();
    check("bp_rden_pulses", rden_cnt - snap, 4);
    check("bp_occupancy", act_occ, 4);
    check("bp_rden_low", act_rden, 0);
    check("bp_head_data", act_data, 8'h40);
    snap = pop_cnt;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) tick();
    check("bp_delivered", pop_cnt - snap, 10);
    check("bp_read_count", act_rc, 10);
    check("bp_occupancy_end", act_occ, 0);

    // reset with a read in flight
    select_dut(2);
    out_ready = 1'b1;
    tick();
    push_word(8'h77, 1'b0);
    #1;
    check("mid_rden", act_rden, 1);
    tick();
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("mid_valid", act_valid, 0);
      check("mid_occupancy", act_occ, 0);
      tick();
    end

    // ReadCount wrap
    select_dut(1);
    out_ready = 1'b1;
    tick();
    snap = pop_cnt;
    for (int i = 0; i < 65537; i++) push_word(8'(i), 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 70000) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("wrap_pops", pop_cnt - snap, 65537);
    check("wrap_read_count", act_rc, 16'h0001);
    check("wrap_occupancy", act_occ, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
